bcd_scan_ctrl: RTL and testbench

Sequencing controller for the shared two-digit `binbcd` converter and the multiplexed 7-segment display. Up to NVAL requesters each submit an 8-bit value. A round-robin arbiter time-shares the single external `binbcd` instance between them and stores each result in a digit register file. A refresh scanner then cycles those digits onto the common display bus. The block sits between the game/score logic and the 7-segment decoder.

---
 rtl/bcd_scan_ctrl.sv | 152 +++++++++++++++
 tb/tb_bcd_scan_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_ctrl.sv
// Round-robin sequencer sharing one combinational binbcd converter among NVAL
// requesters, plus a refresh scanner that multiplexes the stored digits.
module bcd_scan_ctrl #(
  parameter int NVAL        = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NVAL-1:0]      req,
  input  logic [8*NVAL-1:0]    val_in,
  output logic [NVAL-1:0]      ack,
  output logic [7:0]           bin_out,
  input  logic [3:0]           bcd0_in,
  input  logic [3:0]           bcd1_in,
  output logic [NVAL-1:0]      ovf,
  output logic [2*NVAL-1:0]    dig_en,
  output logic [3:0]           dig_val
);

  localparam int IW = (NVAL > 1) ? $clog2(NVAL) : 1;
  localparam int ND = 2 * NVAL;
  localparam int DW = $clog2(ND);
  localparam int VW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]      bin_q, bin_d;
  logic [NVAL-1:0] ack_q, ack_d;
  logic            capture;
  logic            found;
  logic [IW-1:0]   pick;
  logic [IW:0]     sum;

  logic [3:0]      units_q [NVAL];
  logic [3:0]      tens_q  [NVAL];
  logic [NVAL-1:0] ovf_q;

  logic [VW-1:0]   div_q, div_d;
  logic [DW-1:0]   idx_q, idx_d;
  logic [ND-1:0]   dig_en_q, dig_en_d;
  logic [3:0]      dig_val_q, dig_val_d;
  logic            tick;
  logic [IW-1:0]   slot;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case/if can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    bin_d    = bin_q;
    ack_d    = '0;
    capture  = 1'b0;
    found    = 1'b0;
    pick     = '0;
    sum      = '0;

    // Search starts at rr_ptr and wraps, so the first hit is the fair winner.
    for (int off = 0; off < NVAL; off++) begin
      sum = {1'b0, rr_ptr_q} + (IW+1)'(off);
      if (sum >= (IW+1)'(NVAL)) sum = sum - (IW+1)'(NVAL);
      if (!found && req[sum[IW-1:0]]) begin
        found = 1'b1;
        pick  = sum[IW-1:0];
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          bin_d   = val_in[8*pick +: 8];
          state_d = CONV;
        end
      end
      CONV: begin
        capture        = 1'b1;
        ack_d[grant_q] = 1'b1;
        state_d        = DONE;
      end
      DONE: begin
        rr_ptr_d = (grant_q == IW'(NVAL-1)) ? '0 : grant_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      bin_q    <= '0;
      ack_q    <= '0;
      ovf_q    <= '0;
      // NOTE: the digit file is reset explicitly; the display must read zero
      // after reset, so this cannot be left to an uninitialised RAM.
      for (int i = 0; i < NVAL; i++) begin
        units_q[i] <= '0;
        tens_q[i]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      bin_q    <= bin_d;
      ack_q    <= ack_d;
      if (capture) begin
        units_q[grant_q] <= bcd0_in;
        tens_q[grant_q]  <= bcd1_in;
        ovf_q[grant_q]   <= (bcd0_in == 4'hF);
      end
    end
  end

  always_comb begin
    tick      = (div_q == VW'(REFRESH_DIV-1));
    div_d     = tick ? '0 : div_q + 1'b1;
    idx_d     = idx_q;
    if (tick) idx_d = (idx_q == DW'(ND-1)) ? '0 : idx_q + 1'b1;
    slot      = IW'(idx_q >> 1);
    dig_en_d  = ~(ND'(1) << idx_q);
    dig_val_d = idx_q[0] ? tens_q[slot] : units_q[slot];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q     <= '0;
      idx_q     <= '0;
      dig_en_q  <= '1;
      dig_val_q <= '0;
    end else begin
      div_q     <= div_d;
      idx_q     <= idx_d;
      dig_en_q  <= dig_en_d;
      dig_val_q <= dig_val_d;
    end
  end

  assign ack     = ack_q;
  assign bin_out = bin_q;
  assign ovf     = ovf_q;
  assign dig_en  = dig_en_q;
  assign dig_val = dig_val_q;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Scoreboard bench: stimulus queues expected grants, a monitor checks each ack;
// a second small instance exercises the refresh scanner timing.
module tb_bcd_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // NVAL=4 instance
  logic [3:0]  req4;
  logic [31:0] val4;
  logic [3:0]  ack4, ovf4, dval4;
  logic [7:0]  bin4, den4;
  logic [3:0]  b0_4, b1_4;

  // NVAL=2, REFRESH_DIV=4 instance
  logic [1:0]  req2, ack2, ovf2;
  logic [15:0] val2;
  logic [7:0]  bin2;
  logic [3:0]  b0_2, b1_2, den2, dval2;

  // Behavioural binbcd: >99 yields units=F, tens=0
  assign b0_4 = (bin4 > 8'd99) ? 4'hF : 4'(bin4 % 8'd10);
  assign b1_4 = (bin4 > 8'd99) ? 4'h0 : 4'(bin4 / 8'd10);
  assign b0_2 = (bin2 > 8'd99) ? 4'hF : 4'(bin2 % 8'd10);
  assign b1_2 = (bin2 > 8'd99) ? 4'h0 : 4'(bin2 / 8'd10);

  bcd_scan_ctrl #(.NVAL(4), .REFRESH_DIV(3)) dut (
    .clk(clk), .rst_n(rst_n), .req(req4), .val_in(val4), .ack(ack4),
    .bin_out(bin4), .bcd0_in(b0_4), .bcd1_in(b1_4), .ovf(ovf4),
    .dig_en(den4), .dig_val(dval4)
  );

  bcd_scan_ctrl #(.NVAL(2), .REFRESH_DIV(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .val_in(val2), .ack(ack2),
    .bin_out(bin2), .bcd0_in(b0_2), .bcd1_in(b1_2), .ovf(ovf2),
    .dig_en(den2), .dig_val(dval2)
  );

  typedef struct {
    int   idx;
    logic ov;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int idx, input logic ov);
    exp_t x;
    x.idx = idx;
    x.ov  = ov;
    q.push_back(x);
  endtask

  // Monitor: every ack pulse must match the next queued grant
  always @(negedge clk) begin
    if (ack4 != 4'b0) begin
      if (q.size() == 0) begin
        check("spurious_ack", 32'(ack4), 32'd0);
      end else begin
        e = q.pop_front();
        check("ack_order", 32'(ack4), 32'(4'b1 << e.idx));
        check("ovf_flag", 32'(ovf4[e.idx[1:0]]), 32'(e.ov));
      end
    end
  end

  // Requester model: drop each req bit when its ack is seen
  task automatic serve4(input logic [3:0] mask, input logic [31:0] vals);
    int n;
    @(negedge clk);
    val4 = vals;
    req4 = mask;
    n = 0;
    while (req4 != 4'b0 && n < 40) begin
      @(negedge clk);
      req4 = req4 & ~ack4;
      n++;
    end
    if (req4 != 4'b0) begin
      check("serve_timeout", 32'(req4), 32'd0);
      req4 = 4'b0;
    end
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
  endtask

  task automatic read_digit(input int d, input logic [3:0] exp);
    logic [7:0] tgt;
    int n;
    tgt = ~(8'd1 << d);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (den4 != tgt && n < 100);
    if (den4 != tgt) check($sformatf("scan_timeout_d%0d", d), 32'(den4), 32'(tgt));
    else             check($sformatf("digit_%0d", d), 32'(dval4), 32'(exp));
  endtask

  logic [3:0] en_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [3:0] v_tab  [4] = '{4'd2, 4'd4, 4'd3, 4'd1};

  initial begin
    logic [3:0] prev;
    int n;
    rst_n = 1'b0;
    req4 = '0; val4 = '0; req2 = '0; val2 = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack4), 32'd0);
    check("rst_bin", 32'(bin4), 32'd0);
    check("rst_ovf", 32'(ovf4), 32'd0);
    check("rst_den4", 32'(den4), 32'hFF);
    check("rst_dval", 32'(dval4), 32'd0);
    check("rst_den2", 32'(den2), 32'hF);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_den4", 32'(den4), 32'hFE);
    check("first_den2", 32'(den2), 32'hE);

    // All four requesting at once, rr_ptr=0: served 0,1,2,3
    push(0, 1'b0); push(1, 1'b0); push(2, 1'b0); push(3, 1'b0);
    serve4(4'b1111, {8'd99, 8'd63, 8'd19, 8'd7});
    read_digit(0, 4'd7); read_digit(1, 4'd0);
    read_digit(2, 4'd9); read_digit(3, 4'd1);
    read_digit(4, 4'd3); read_digit(5, 4'd6);
    read_digit(6, 4'd9); read_digit(7, 4'd9);

    // Single request, latency checked cycle by cycle
    push(2, 1'b0);
    @(negedge clk);
    val4 = {8'd0, 8'd42, 8'd0, 8'd0};
    req4 = 4'b0100;
    @(negedge clk);
    check("bin_latency", 32'(bin4), 32'h2A);
    check("ack_early", 32'(ack4), 32'd0);
    @(negedge clk);
    check("ack_latency", 32'(ack4), 32'h4);
    req4 = 4'b0;
    @(negedge clk);
    check("ack_one_cycle", 32'(ack4), 32'd0);
    read_digit(4, 4'd2); read_digit(5, 4'd4);

    // Out-of-range value, then ovf cleared by an in-range one
    push(1, 1'b1);
    serve4(4'b0010, {8'd0, 8'd0, 8'd150, 8'd0});
    read_digit(2, 4'hF); read_digit(3, 4'h0);
    push(1, 1'b0);
    serve4(4'b0010, {8'd0, 8'd0, 8'd5, 8'd0});
    check("ovf_cleared", 32'(ovf4), 32'd0);
    read_digit(2, 4'd5); read_digit(3, 4'd0);

    // Scanner walk on the small instance
    @(negedge clk);
    val2 = {8'd13, 8'd42};
    req2 = 2'b11;
    n = 0;
    while (req2 != 2'b0 && n < 40) begin
      @(negedge clk);
      req2 = req2 & ~ack2;
      n++;
    end
    if (req2 != 2'b0) begin
      check("serve2_timeout", 32'(req2), 32'd0);
      req2 = 2'b0;
    end
    prev = den2;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (prev != 4'hE && den2 == 4'hE) break;
      prev = den2;
    end while (n < 100);
    if (den2 != 4'hE) check("scan2_sync", 32'(den2), 32'hE);
    for (int s = 0; s < 5; s++) begin
      for (int c = 0; c < 4; c++) begin
        if (s != 0 || c != 0) @(negedge clk);
        check($sformatf("scan_en_s%0d_c%0d", s, c), 32'(den2), 32'(en_tab[s % 4]));
        check($sformatf("scan_val_s%0d_c%0d", s, c), 32'(dval2), 32'(v_tab[s % 4]));
      end
    end

    // Reset while in CONV: no ack, digits cleared, normal service afterwards
    @(negedge clk);
    val4 = {8'd0, 8'd0, 8'd0, 8'd77};
    req4 = 4'b0001;
    @(negedge clk);
    rst_n = 1'b0;
    req4 = 4'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_ack", 32'(ack4), 32'd0);
    end
    rst_n = 1'b1;
    read_digit(0, 4'd0); read_digit(5, 4'd0);
    push(3, 1'b0);
    serve4(4'b1000, {8'd88, 8'd0, 8'd0, 8'd0});
    read_digit(6, 4'd8); read_digit(7, 4'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
